power_mode_controller: RTL and testbench
========================================

// Module: power_mode_controller
// PURPOSE
//  Parametrised core power-mode FSM. Generalises the 2-state sleep controller with four states,
//  pipeline drain, N masked wake sources, an idle auto-sleep timer and a timed wake ramp.
//  Sits beside the pipelined RV32I core; drives fetch stall and the core clock-gate enable.
// PARAMETERS
//  NUM_WAKE_SRC  4    number of wake sources (>=1)
//  IDLE_CNT_W    8    idle counter width
//  IDLE_TIMEOUT  200  idle cycles before auto-sleep (1..2**IDLE_CNT_W-1)
//  DRAIN_CYCLES  4    consecutive pipe_idle cycles required in DRAIN (>=1)
//  WAKE_CYCLES   8    clock-restore settle cycles in WAKE (>=1)
// PORTS
//  clk              in   1             core clock
//  rst              in   1             asynchronous, active-high reset
//  sleep_request    in   1             request entry to sleep (level, sampled in ACTIVE)
//  auto_sleep_en    in   1             enable idle-timeout auto-sleep
//  pipe_idle        in   1             pipeline empty, no outstanding memory ops
//  wakeup_src       in   NUM_WAKE_SRC  wake events, level, synchronous to clk
//  wake_mask        in   NUM_WAKE_SRC  1 = source enabled for wake
//  stall_out        out  1             freeze fetch
//  clk_en_out       out  1             core clock-gate enable
//  sleep_state_out  out  1             1 while in SLEEP
//  wake_cause       out  NUM_WAKE_SRC  masked sources that caused the last wake or abort
//  state_out        out  2             ACTIVE=0, DRAIN=1, SLEEP=2, WAKE=3
// BEHAVIOUR
//  Reset (async, any state): state ACTIVE, stall_out=0, clk_en_out=1, sleep_state_out=0,
//   wake_cause=0, idle/drain/wake counters=0.
//  All outputs registered and aligned with the state register: decoded from next_state.
//  wake_ev = |(wakeup_src & wake_mask).
//  ACTIVE: idle_cnt increments while pipe_idle && auto_sleep_en, else clears to 0.
//   -> DRAIN on sleep_request, or on idle_cnt==IDLE_TIMEOUT-1 && pipe_idle && auto_sleep_en.
//   Entry is refused (stay ACTIVE) when wake_mask==0, to prevent unrecoverable sleep.
//   wake_ev ignored in ACTIVE. idle_cnt saturates and never wraps.
//  DRAIN: stall_out=1, clk_en_out=1. On entry, clear wake_cause and drain_cnt.
//   drain_cnt clears whenever pipe_idle=0.
//   -> SLEEP when pipe_idle && drain_cnt==DRAIN_CYCLES-1 (exactly DRAIN_CYCLES idle cycles).
//   wake_ev in DRAIN aborts: -> ACTIVE, wake_cause <= wakeup_src & wake_mask.
//   The abort has priority over completion in the same cycle.
//  SLEEP: stall_out=1, clk_en_out=0, sleep_state_out=1.
//   -> WAKE on wake_ev; wake_cause <= wakeup_src & wake_mask; sleep_request ignored.
//  WAKE: stall_out=1, clk_en_out=1, sleep_state_out=0; wake_cnt counts from 0.
//   -> ACTIVE when wake_cnt==WAKE_CYCLES-1 (exactly WAKE_CYCLES cycles).
//   Inputs ignored. On ACTIVE entry, idle_cnt=0.
//  wake_cause holds its value until the next DRAIN entry or reset.
//  Illegal state encoding: -> ACTIVE next cycle.
//  Counters are sized $clog2(max(param,2)) bits.
// TESTING
//  1 rst=1 mid-SLEEP -> state_out=0, clk_en_out=1, stall_out=0, wake_cause=0 with no clk edge needed.
//  2 mask=4'b0001, sleep_request pulse, pipe_idle=1:
//    -> DRAIN for 4 cycles, then SLEEP (clk_en_out=0).
//    src[0]=1 -> WAKE for 8 cycles, then ACTIVE; wake_cause=4'b0001.
//  3 DRAIN with pipe_idle toggling 1,1,0,1,1,1,1 -> SLEEP only after the last 4 idle cycles.
//  4 In DRAIN, src[2]=1, mask=4'b0100 -> ACTIVE next cycle, wake_cause=4'b0100, never SLEEP.
//  5 auto_sleep_en=1, pipe_idle=1 for 200 cycles -> DRAIN entered on the 200th cycle.
//    A pipe_idle drop at cycle 150 restarts the count.
//  6 mask=0, sleep_request=1 -> stays ACTIVE.
//    In SLEEP with src=4'b1010, mask=4'b0010 -> wake_cause=4'b0010.

Source files
------------

// File: rtl/power_mode_controller.sv
// Core power-mode FSM: ACTIVE -> DRAIN -> SLEEP -> WAKE -> ACTIVE, with masked wake
// sources, idle auto-sleep timer, drain abort and timed clock-restore ramp.
module power_mode_controller #(
  parameter int unsigned NUM_WAKE_SRC = 4,
  parameter int unsigned IDLE_CNT_W   = 8,
  parameter int unsigned IDLE_TIMEOUT = 200,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sleep_request,
  input  logic                    auto_sleep_en,
  input  logic                    pipe_idle,
  input  logic [NUM_WAKE_SRC-1:0] wakeup_src,
  input  logic [NUM_WAKE_SRC-1:0] wake_mask,
  output logic                    stall_out,
  output logic                    clk_en_out,
  output logic                    sleep_state_out,
  output logic [NUM_WAKE_SRC-1:0] wake_cause,
  output logic [1:0]              state_out
);

  localparam int unsigned DRAIN_W = $clog2((DRAIN_CYCLES > 2) ? DRAIN_CYCLES : 2);
  localparam int unsigned WAKE_W  = $clog2((WAKE_CYCLES > 2) ? WAKE_CYCLES : 2);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST  = IDLE_CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [WAKE_W-1:0]     WAKE_LAST  = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_WAKE   = 2'd3
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [IDLE_CNT_W-1:0]   idle_cnt;
  logic [DRAIN_W-1:0]      drain_cnt;
  logic [WAKE_W-1:0]       wake_cnt;
  logic [NUM_WAKE_SRC-1:0] wake_hits;
  logic                    wake_ev;
  logic                    idle_tick;
  logic                    sleep_allowed;
  logic                    sleep_trigger;

  assign wake_hits     = wakeup_src & wake_mask;
  assign wake_ev       = |wake_hits;
  assign idle_tick     = pipe_idle & auto_sleep_en;
  // Without any enabled wake source, sleep could never be left.
  assign sleep_allowed = |wake_mask;
  assign sleep_trigger = sleep_request | (idle_tick && (idle_cnt == IDLE_LAST));
  assign state_out     = state;

  always_comb begin
    next_state = state;
    case (state)
      ST_ACTIVE: begin
        if (sleep_trigger && sleep_allowed) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wake abort outranks drain completion.
        if (wake_ev)                                    next_state = ST_ACTIVE;
        else if (pipe_idle && (drain_cnt == DRAIN_LAST)) next_state = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (wake_ev) next_state = ST_WAKE;
      end
      ST_WAKE: begin
        if (wake_cnt == WAKE_LAST) next_state = ST_ACTIVE;
      end
      default: next_state = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_ACTIVE;
      stall_out       <= 1'b0;
      clk_en_out      <= 1'b1;
      sleep_state_out <= 1'b0;
      wake_cause      <= '0;
      idle_cnt        <= '0;
      drain_cnt       <= '0;
      wake_cnt        <= '0;
    end else begin
      state           <= next_state;
      stall_out       <= (next_state != ST_ACTIVE);
      clk_en_out      <= (next_state != ST_SLEEP);
      sleep_state_out <= (next_state == ST_SLEEP);

      // Idle timer only runs in ACTIVE, so every ACTIVE entry starts it from zero.
      if ((state == ST_ACTIVE) && idle_tick) begin
        if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end

      // Counting only while staying in the state keeps the counter at zero on entry.
      if ((state == ST_DRAIN) && (next_state == ST_DRAIN) && pipe_idle)
        drain_cnt <= drain_cnt + 1'b1;
      else
        drain_cnt <= '0;

      if ((state == ST_WAKE) && (next_state == ST_WAKE))
        wake_cnt <= wake_cnt + 1'b1;
      else
        wake_cnt <= '0;

      if ((state == ST_ACTIVE) && (next_state == ST_DRAIN))
        wake_cause <= '0;
      else if (((state == ST_DRAIN) && (next_state == ST_ACTIVE)) ||
               ((state == ST_SLEEP) && (next_state == ST_WAKE)))
        wake_cause <= wake_hits;
    end
  end

endmodule

// File: tb/tb_power_mode_controller.sv
// Bench for power_mode_controller: directed vector table, hand sequences for the
// timer / async reset corners, then randomized traffic against a cycle model.
module tb_power_mode_controller;

  localparam int IDLE_TIMEOUT = 200;
  localparam int DRAIN_CYCLES = 4;
  localparam int WAKE_CYCLES  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sleep_request = 1'b0;
  logic       auto_sleep_en = 1'b0;
  logic       pipe_idle = 1'b0;
  logic [3:0] wakeup_src = '0;
  logic [3:0] wake_mask = '0;
  logic       stall_out, clk_en_out, sleep_state_out;
  logic [3:0] wake_cause;
  logic [1:0] state_out;

  int total = 0;
  int bad = 0;

  power_mode_controller #(
    .NUM_WAKE_SRC(4),
    .IDLE_CNT_W(8),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sleep_request(sleep_request),
    .auto_sleep_en(auto_sleep_en),
    .pipe_idle(pipe_idle),
    .wakeup_src(wakeup_src),
    .wake_mask(wake_mask),
    .stall_out(stall_out),
    .clk_en_out(clk_en_out),
    .sleep_state_out(sleep_state_out),
    .wake_cause(wake_cause),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         reps;
    logic       sr, ase, pi;
    logic [3:0] src, mask;
    logic [1:0] st;
    logic       stall, clk_en, slp;
    logic [3:0] cause;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int reps, logic sr, logic ase, logic pi, logic [3:0] src,
                              logic [3:0] mask, logic [1:0] st, logic stall, logic clk_en,
                              logic slp, logic [3:0] cause);
    vec_t v;
    v.reps = reps; v.sr = sr; v.ase = ase; v.pi = pi; v.src = src; v.mask = mask;
    v.st = st; v.stall = stall; v.clk_en = clk_en; v.slp = slp; v.cause = cause;
    return v;
  endfunction

  task automatic chk(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {state_out, stall_out, clk_en_out, sleep_state_out, wake_cause};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got st=%0d stall=%b clk_en=%b slp=%b cause=%b, expected st=%0d stall=%b clk_en=%b slp=%b cause=%b",
               name, $time, act[8:7], act[6], act[5], act[4], act[3:0],
               exp[8:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic sr, input logic ase, input logic pi,
                       input logic [3:0] src, input logic [3:0] mask);
    @(negedge clk);
    sleep_request = sr; auto_sleep_en = ase; pipe_idle = pi;
    wakeup_src = src; wake_mask = mask;
    @(posedge clk);
    #1;
  endtask

  // Reference model: 0=ACTIVE 1=DRAIN 2=SLEEP 3=WAKE, runs counted as plain integers.
  int         m_mode, m_idle_run, m_drain_run, m_wake_run;
  logic [3:0] m_cause;

  task automatic model_reset();
    m_mode = 0; m_idle_run = 0; m_drain_run = 0; m_wake_run = 0; m_cause = '0;
  endtask

  task automatic model_step(input logic sr, input logic ase, input logic pi,
                            input logic [3:0] src, input logic [3:0] mask);
    logic [3:0] hits;
    hits = src & mask;
    case (m_mode)
      0: begin
        m_idle_run = (ase && pi) ? m_idle_run + 1 : 0;
        if ((sr || m_idle_run == IDLE_TIMEOUT) && mask != 0) begin
          m_mode = 1; m_drain_run = 0; m_cause = '0;
        end
      end
      1: begin
        m_drain_run = pi ? m_drain_run + 1 : 0;
        if (hits != 0) begin
          m_mode = 0; m_idle_run = 0; m_cause = hits;
        end else if (m_drain_run == DRAIN_CYCLES) begin
          m_mode = 2;
        end
      end
      2: begin
        if (hits != 0) begin
          m_mode = 3; m_wake_run = 0; m_cause = hits;
        end
      end
      default: begin
        m_wake_run++;
        if (m_wake_run == WAKE_CYCLES) begin
          m_mode = 0; m_idle_run = 0;
        end
      end
    endcase
  endtask

  function automatic logic [8:0] model_out();
    logic [1:0] st;
    st = 2'(m_mode);
    return {st, m_mode != 0, m_mode != 2, m_mode == 2, m_cause};
  endfunction

  initial begin
    // Reset
    @(posedge clk); #1;
    chk("reset_hold", {2'd0, 1'b0, 1'b1, 1'b0, 4'b0000});
    @(negedge clk); rst = 1'b0;

    // Directed table: args are reps, sr, ase, pi, src, mask, st, stall, clk_en, slp, cause
    tbl.push_back(mk(1, 0, 0, 1, 4'h0, 4'h1, 0, 0, 1, 0, 4'h0));
    tbl.push_back(mk(1, 1, 0, 1, 4'h0, 4'h1, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(3, 0, 0, 1, 4'h0, 4'h1, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 1, 4'h0, 4'h1, 2, 1, 0, 1, 4'h0));
    tbl.push_back(mk(2, 1, 0, 1, 4'h0, 4'h1, 2, 1, 0, 1, 4'h0));
    tbl.push_back(mk(1, 0, 0, 1, 4'h1, 4'h1, 3, 1, 1, 0, 4'h1));
    tbl.push_back(mk(7, 1, 0, 0, 4'hF, 4'h1, 3, 1, 1, 0, 4'h1));
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 4'h1, 0, 0, 1, 0, 4'h1));
    // abort right after entry
    tbl.push_back(mk(1, 1, 0, 1, 4'h0, 4'h4, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 1, 4'h4, 4'h4, 0, 0, 1, 0, 4'h4));
    tbl.push_back(mk(5, 0, 0, 1, 4'h0, 4'h4, 0, 0, 1, 0, 4'h4));
    // abort on the completing cycle
    tbl.push_back(mk(1, 1, 0, 1, 4'h0, 4'h4, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(3, 0, 0, 1, 4'h0, 4'h4, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 1, 4'h6, 4'h4, 0, 0, 1, 0, 4'h4));
    // sleep refused with empty mask
    tbl.push_back(mk(3, 1, 0, 1, 4'h0, 4'h0, 0, 0, 1, 0, 4'h4));
    // drain with pipe_idle 1,1,0,1,1,1,1
    tbl.push_back(mk(1, 1, 0, 1, 4'h0, 4'h2, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(2, 0, 0, 1, 4'h0, 4'h2, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h2, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(3, 0, 0, 1, 4'h0, 4'h2, 1, 1, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 1, 4'h0, 4'h2, 2, 1, 0, 1, 4'h0));
    // unmasked source does not wake; then masked partial wake
    tbl.push_back(mk(2, 0, 0, 1, 4'h8, 4'h2, 2, 1, 0, 1, 4'h0));
    tbl.push_back(mk(1, 0, 0, 1, 4'hA, 4'h2, 3, 1, 1, 0, 4'h2));
    tbl.push_back(mk(7, 0, 0, 1, 4'h0, 4'h2, 3, 1, 1, 0, 4'h2));
    tbl.push_back(mk(1, 0, 0, 1, 4'h0, 4'h2, 0, 0, 1, 0, 4'h2));
    // wake events ignored in ACTIVE
    tbl.push_back(mk(2, 0, 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 4'h2));

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        drive(tbl[i].sr, tbl[i].ase, tbl[i].pi, tbl[i].src, tbl[i].mask);
        chk($sformatf("vec%0d_r%0d", i, r),
            {tbl[i].st, tbl[i].stall, tbl[i].clk_en, tbl[i].slp, tbl[i].cause});
      end
    end

    // Auto-sleep: 149 idle cycles, a drop at cycle 150, then a fresh 200-cycle run
    for (int c = 1; c <= 149; c++) drive(0, 1, 1, 4'h0, 4'h1);
    chk("auto_149", {2'd0, 1'b0, 1'b1, 1'b0, 4'h2});
    drive(0, 1, 0, 4'h0, 4'h1);
    chk("auto_drop", {2'd0, 1'b0, 1'b1, 1'b0, 4'h2});
    for (int c = 1; c <= 199; c++) drive(0, 1, 1, 4'h0, 4'h1);
    chk("auto_199", {2'd0, 1'b0, 1'b1, 1'b0, 4'h2});
    drive(0, 1, 1, 4'h0, 4'h1);
    chk("auto_200_drain", {2'd1, 1'b1, 1'b1, 1'b0, 4'h0});
    for (int c = 1; c <= 4; c++) drive(0, 1, 1, 4'h0, 4'h1);
    chk("auto_sleep", {2'd2, 1'b1, 1'b0, 1'b1, 4'h0});

    // Async reset mid-SLEEP, observed before any clock edge
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_reset", {2'd0, 1'b0, 1'b1, 1'b0, 4'h0});
    @(negedge clk); rst = 1'b0;

    // Randomized traffic against the model
    model_reset();
    sleep_request = 0; auto_sleep_en = 0; pipe_idle = 0; wakeup_src = '0; wake_mask = 4'h3;
    for (int c = 0; c < 6000; c++) begin
      logic       sr, ase, pi, do_rst;
      logic [3:0] src, mask;
      bit         quiet;
      quiet  = ((c / 800) % 2) == 1;
      sr     = quiet ? 1'b0 : ($urandom_range(0, 19) == 0);
      ase    = ($urandom_range(0, 3) != 0);
      pi     = quiet ? ($urandom_range(0, 499) != 0) : ($urandom_range(0, 3) != 0);
      src    = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      mask   = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(0, 15)) : wake_mask;
      do_rst = ($urandom_range(0, 999) == 0);
      @(negedge clk);
      rst = do_rst;
      sleep_request = sr; auto_sleep_en = ase; pipe_idle = pi;
      wakeup_src = src; wake_mask = mask;
      @(posedge clk);
      #1;
      if (do_rst) model_reset();
      else        model_step(sr, ase, pi, src, mask);
      chk($sformatf("rand%0d", c), model_out());
    end
    @(negedge clk); rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
